// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its lane aligner.
package dmem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 14;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    PROG      = 2'd2
  } dmem_state_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) || ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;

  assign w_shamt   = {i_ld_off, 3'b000};
  assign w_shifted = i_ld_rdata >> w_shamt;

  // Store path: narrow data is replicated so every enabled lane sees it.
  always_comb begin
    o_st_be    = 4'h0;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_B: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_H: begin
        o_st_be    = 4'b0011 << i_st_off;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      SZ_W: o_st_be = 4'hF;
      default: o_st_be = 4'h0;
    endcase
  end

  // Load path: shift the addressed lane down, then extend.
  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_B: o_ld_data = i_ld_unsigned ? {24'd0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_ld_data = i_ld_unsigned ? {16'd0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU load/store decode, load wait state and
// exclusive RAM ownership for the UART programmer.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic              cpu_fault,
  input  logic              upg_active,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_adr,
  input  logic [31:0]       upg_dat,
  input  logic              upg_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  dmem_state_t r_state;
  dmem_state_t w_state_next;

  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic        r_inr;
  logic        r_upg_armed;

  logic        w_in_range;
  logic        w_misaligned;
  logic        w_upg_req;
  logic        w_ld_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_in_range   = (cpu_addr[31:16] == 16'd0);
  assign w_misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
  // Programmer request is edge-qualified: armed only after upg_active has been low.
  assign w_upg_req    = upg_active && r_upg_armed;
  assign w_ld_go      = (r_state == RUN) && !w_upg_req && cpu_req && !cpu_we && !w_misaligned;

  dmem_lane_align u_align (
    .i_st_size     (cpu_size),
    .i_st_off      (cpu_addr[1:0]),
    .i_st_wdata    (cpu_wdata),
    .o_st_be       (w_be),
    .o_st_wdata    (w_wdata_rep),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_uns),
    .i_ld_rdata    (ram_rdata),
    .o_ld_data     (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_size      <= SZ_B;
      r_uns       <= 1'b0;
      r_off       <= 2'd0;
      r_inr       <= 1'b0;
      r_upg_armed <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_ld_go) begin
        r_size <= cpu_size;
        r_uns  <= cpu_unsigned;
        r_off  <= cpu_addr[1:0];
        r_inr  <= w_in_range;
      end
      if (!upg_active) begin
        r_upg_armed <= 1'b1;
      end else if ((r_state == PROG) && upg_done) begin
        r_upg_armed <= 1'b0;
      end
    end
  end

  // RAM ports are driven in the request cycle so the RAM captures on the next edge.
  always_comb begin
    w_state_next = r_state;
    cpu_rdata    = 32'd0;
    cpu_rvalid   = 1'b0;
    cpu_stall    = 1'b0;
    cpu_fault    = 1'b0;
    ram_addr     = '0;
    ram_we       = 4'h0;
    ram_wdata    = 32'd0;
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (w_upg_req) begin
            cpu_stall    = 1'b1;
            w_state_next = PROG;
          end else if (cpu_req) begin
            if (w_misaligned) begin
              cpu_fault = 1'b1;
            end else if (cpu_we) begin
              if (w_in_range) begin
                ram_addr  = cpu_addr[ADDR_W+1:2];
                ram_we    = w_be;
                ram_wdata = w_wdata_rep;
              end
            end else begin
              ram_addr     = cpu_addr[ADDR_W+1:2];
              cpu_stall    = 1'b1;
              w_state_next = LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          cpu_rvalid   = 1'b1;
          cpu_rdata    = r_inr ? w_rdata_ext : 32'd0;
          w_state_next = w_upg_req ? PROG : RUN;
        end
        PROG: begin
          cpu_stall = 1'b1;
          ram_addr  = upg_adr;
          ram_wdata = upg_dat;
          ram_we    = {4{upg_wen}};
          if (upg_done) begin
            w_state_next = RUN;
          end
        end
        default: w_state_next = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-addressed reference memory model plus directed vectors.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]    cpu_size;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_rvalid, cpu_stall, cpu_fault;
  logic          upg_active, upg_wen, upg_done;
  logic [AW-1:0] upg_adr, ram_addr;
  logic [31:0]   upg_dat, ram_wdata, ram_rdata;
  logic [3:0]    ram_we;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .upg_active(upg_active), .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .upg_done(upg_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Four byte-lane RAMs with a registered read port.
  bit [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  // Reference: byte-addressed memory and a coarse view of who owns the RAM.
  bit [7:0]  gmem [0:65535];
  bit        m_prog, m_pend, m_armed;
  bit [31:0] m_pend_data;

  function automatic int nbytes(input bit [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit illegal(input bit [1:0] s, input bit [31:0] a);
    return (s == 2'd3) || ((int'(a[1:0]) % nbytes(s)) != 0);
  endfunction

  function automatic bit [31:0] mem_load(input bit [31:0] a, input bit [1:0] s, input bit u);
    bit [31:0] v;
    int n;
    v = 32'd0;
    n = nbytes(s);
    if (a >= 32'h10000) return 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(gmem[int'(a) + k]) << (8 * k));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit up_req;
    up_req = upg_active && m_armed;
    if (rst) begin
      m_prog  <= 1'b0;
      m_pend  <= 1'b0;
      m_armed <= 1'b1;
    end else begin
      if (!upg_active) m_armed <= 1'b1;
      else if (m_prog && upg_done) m_armed <= 1'b0;
      if (m_prog) begin
        if (upg_wen)
          for (int k = 0; k < 4; k++) gmem[int'(upg_adr) * 4 + k] <= upg_dat[8*k +: 8];
        if (upg_done) m_prog <= 1'b0;
      end else if (m_pend) begin
        m_pend <= 1'b0;
        if (up_req) m_prog <= 1'b1;
      end else if (up_req) begin
        m_prog <= 1'b1;
      end else if (cpu_req && !illegal(cpu_size, cpu_addr)) begin
        if (cpu_we) begin
          if (cpu_addr < 32'h10000)
            for (int k = 0; k < nbytes(cpu_size); k++)
              gmem[int'(cpu_addr) + k] <= cpu_wdata[8*k +: 8];
        end else begin
          m_pend      <= 1'b1;
          m_pend_data <= mem_load(cpu_addr, cpu_size, cpu_unsigned);
        end
      end
    end
  end

  task automatic do_compare();
    bit [31:0] e_rd, e_wd;
    bit [AW-1:0] e_addr;
    bit [3:0] e_we;
    bit e_rv, e_st, e_ft, c_addr, c_wd, c_rd;
    int n, b;
    e_rd = 0; e_wd = 0; e_addr = 0; e_we = 0;
    e_rv = 0; e_st = 0; e_ft = 0; c_addr = 1; c_wd = 1; c_rd = 1;
    if (rst) begin
      e_rv = 0;
    end else if (m_prog) begin
      e_st = 1; e_addr = upg_adr; e_wd = upg_dat; e_we = upg_wen ? 4'hF : 4'h0;
    end else if (m_pend) begin
      e_rv = 1; e_rd = m_pend_data;
    end else if (upg_active && m_armed) begin
      e_st = 1; c_addr = 0; c_wd = 0;
    end else if (cpu_req) begin
      if (illegal(cpu_size, cpu_addr)) begin
        e_ft = 1; c_addr = 0; c_wd = 0;
      end else if (cpu_we) begin
        if (cpu_addr < 32'h10000) begin
          n = nbytes(cpu_size);
          for (int k = 0; k < n; k++) begin
            b = (int'(cpu_addr) + k) % 4;
            e_we[b] = 1'b1;
          end
          for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = cpu_wdata[8*(i % n) +: 8];
          e_addr = AW'(cpu_addr >> 2);
        end else begin
          c_addr = 0; c_wd = 0;
        end
      end else begin
        e_st = 1; e_addr = AW'(cpu_addr >> 2); c_wd = 0;
      end
    end
    if (!rst && !e_rv) c_rd = 0;
    chk("cmp_rvalid", 32'(cpu_rvalid), 32'(e_rv));
    chk("cmp_stall", 32'(cpu_stall), 32'(e_st));
    chk("cmp_fault", 32'(cpu_fault), 32'(e_ft));
    chk("cmp_we", 32'(ram_we), 32'(e_we));
    if (c_rd) chk("cmp_rdata", cpu_rdata, e_rd);
    if (c_addr) chk("cmp_addr", 32'(ram_addr), 32'(e_addr));
    if (c_wd) chk("cmp_wdata", ram_wdata, e_wd);
  endtask

  always @(negedge clk) if (cmp_en) do_compare();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_size = SZ_W; cpu_unsigned = 0; cpu_addr = 0; cpu_wdata = 0;
    upg_wen = 0; upg_done = 0; upg_adr = '0; upg_dat = 0;
  endtask

  task automatic set_req(input bit we, input bit [1:0] sz, input bit u,
                         input bit [31:0] a, input bit [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_unsigned = u; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d,
                       input bit [3:0] xwe);
    set_req(1, sz, 0, a, d);
    @(negedge clk);
    chk("st_we", 32'(ram_we), 32'(xwe));
    chk("st_stall", 32'(cpu_stall), 32'd0);
    step();
    idle();
  endtask

  task automatic load(input bit [1:0] sz, input bit u, input bit [31:0] a, input bit [31:0] exp);
    set_req(0, sz, u, a, 0);
    @(negedge clk);
    chk("ld_stall", 32'(cpu_stall), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("ld_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("ld_data", cpu_rdata, exp);
    step();
  endtask

  task automatic fault_acc(input bit we, input bit [1:0] sz, input bit [31:0] a);
    set_req(we, sz, 0, a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("flt_pulse", 32'(cpu_fault), 32'd1);
    chk("flt_we", 32'(ram_we), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("flt_norv", 32'(cpu_rvalid), 32'd0);
    chk("flt_once", 32'(cpu_fault), 32'd0);
    step();
  endtask

  initial begin
    idle();
    upg_active = 0;
    rst = 1;
    cmp_en = 1;
    step();
    @(negedge clk);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    step();
    rst = 0;
    step();

    // sb then merged word read-back
    set_req(1, SZ_B, 0, 32'h6, 32'h0000_00AB);
    @(negedge clk);
    chk("sb_we", 32'(ram_we), 32'h4);
    chk("sb_wdata", ram_wdata, 32'hABAB_ABAB);
    chk("sb_addr", 32'(ram_addr), 32'd1);
    step();
    idle();
    load(SZ_W, 0, 32'h4, 32'h00AB_0000);

    // extraction and extension of 0x8001FF7F
    store(SZ_W, 32'h20, 32'h8001_FF7F, 4'hF);
    load(SZ_B, 0, 32'h20, 32'h0000_007F);
    load(SZ_B, 0, 32'h21, 32'hFFFF_FFFF);
    load(SZ_H, 1, 32'h22, 32'h0000_8001);
    load(SZ_H, 0, 32'h22, 32'hFFFF_8001);
    load(SZ_B, 1, 32'h21, 32'h0000_00FF);
    load(SZ_H, 0, 32'h20, 32'hFFFF_FF7F);
    load(SZ_W, 0, 32'h20, 32'h8001_FF7F);
    store(SZ_H, 32'h32, 32'h0000_BEEF, 4'b1100);
    load(SZ_W, 0, 32'h30, 32'hBEEF_0000);

    // faults and out-of-range
    fault_acc(0, SZ_W, 32'h2);
    fault_acc(1, SZ_H, 32'h1);
    fault_acc(1, 2'd3, 32'h0);
    fault_acc(0, SZ_W, 32'h21);
    load(SZ_W, 0, 32'h0001_0000, 32'd0);
    store(SZ_W, 32'h0001_0004, 32'hDEAD_BEEF, 4'h0);
    load(SZ_W, 0, 32'h4, 32'h00AB_0000);

    // programmer request arriving during LOAD_WAIT
    set_req(0, SZ_W, 0, 32'h20, 0);
    step();
    idle();
    upg_active = 1;
    @(negedge clk);
    chk("upl_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("upl_data", cpu_rdata, 32'h8001_FF7F);
    step();
    for (int i = 0; i < 3; i++) begin
      set_req(1, SZ_W, 0, 32'h44, 32'h1234_5678);
      upg_wen = 1; upg_adr = AW'(16 + i); upg_dat = 32'hA0A0_0000 + 32'(i);
      upg_done = (i == 2);
      @(negedge clk);
      chk("prog_stall", 32'(cpu_stall), 32'd1);
      chk("prog_we", 32'(ram_we), 32'hF);
      step();
    end
    upg_wen = 0; upg_done = 0;
    @(negedge clk);
    chk("post_stall", 32'(cpu_stall), 32'd0);
    chk("post_we", 32'(ram_we), 32'hF);
    step();
    idle();
    upg_active = 0;
    load(SZ_W, 0, 32'h40, 32'hA0A0_0000);
    load(SZ_W, 0, 32'h44, 32'h1234_5678);
    load(SZ_W, 0, 32'h48, 32'hA0A0_0002);

    // upg_active beats a same-cycle store; reset mid-PROG
    upg_active = 1;
    set_req(1, SZ_W, 0, 32'h50, 32'h55);
    @(negedge clk);
    chk("prio_stall", 32'(cpu_stall), 32'd1);
    chk("prio_we", 32'(ram_we), 32'd0);
    step();
    idle();
    upg_wen = 1; upg_adr = AW'(20); upg_dat = 32'h7777_7777;
    step();
    rst = 1; upg_active = 0; upg_wen = 0;
    @(negedge clk);
    chk("rstp_stall", 32'(cpu_stall), 32'd0);
    step();
    rst = 0; upg_wen = 1; upg_adr = AW'(21); upg_dat = 32'h99;
    @(negedge clk);
    chk("rstp_we", 32'(ram_we), 32'd0);
    chk("rstp_stall2", 32'(cpu_stall), 32'd0);
    step();
    idle();
    load(SZ_W, 0, 32'h54, 32'd0);
    load(SZ_W, 0, 32'h50, 32'h7777_7777);

    // reset during LOAD_WAIT discards the load
    set_req(0, SZ_W, 0, 32'h50, 0);
    step();
    idle();
    rst = 1;
    @(negedge clk);
    chk("rstl_rvalid", 32'(cpu_rvalid), 32'd0);
    step();
    rst = 0;
    @(negedge clk);
    chk("rstl_rvalid2", 32'(cpu_rvalid), 32'd0);
    step();
    step();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
